// File: rtl/arashi_thread_queue_mem.sv
// ---------------------------------------------------------------------------
// arashi_thread_queue_mem
//   Storage array for arashi_thread_queue: DEPTH x DATA_WIDTH register file.
//   One write port (written on the rising clock edge) and one read port
//   (combinational). Every entry is cleared by reset so that a freshly reset
//   queue never exposes stale payload.
//
// Ports
//   clk      in   clock, rising edge
//   rstn     in   synchronous active-low reset, clears every entry
//   w_en     in   write strobe
//   w_addr   in   write entry index
//   w_data   in   write payload
//   r_addr   in   read entry index
//   r_data   out  payload at r_addr (combinational)
// ---------------------------------------------------------------------------
module arashi_thread_queue_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     w_en,
    input  logic [$clog2(DEPTH)-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0]    w_data,
    input  logic [$clog2(DEPTH)-1:0] r_addr,
    output logic [DATA_WIDTH-1:0]    r_data
);

    logic [DATA_WIDTH-1:0] entries [DEPTH];

    // NOTE: a resettable array cannot map onto RAM macros; it is kept as
    // flops here because reset must guarantee all-zero contents.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (w_en) begin
            entries[w_addr] <= w_data;
        end
    end

    assign r_data = entries[r_addr];

endmodule

// File: rtl/arashi_thread_queue.sv
// ---------------------------------------------------------------------------
// arashi_thread_queue
//   Single-clock FIFO for thread descriptors. All DEPTH entries are usable;
//   occupancy is held in a dedicated counter rather than derived from the
//   pointer difference. Reads return data one cycle after acceptance on a
//   registered data_out; there is no empty-queue bypass.
//
// Ports
//   clk       in   clock, rising edge
//   rstn      in   synchronous active-low reset (highest priority)
//   flush     in   synchronous clear of pointers/count/pulses
//   w_ena     in   write request
//   data_in   in   write payload
//   w_ready   out  registered pulse: write accepted on last edge
//   r_ena     in   read request
//   data_out  out  registered read payload, held between reads
//   r_valid   out  registered pulse: data_out updated on last edge
//   avail     out  combinational lookahead: a read next cycle will succeed
//   count     out  registered occupancy 0..DEPTH
//   full      out  count == DEPTH
//   afull     out  count >= AFULL_LVL
//   ovf_err   out  sticky: a write was dropped because the queue was full
// ---------------------------------------------------------------------------
module arashi_thread_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AFULL_LVL  = DEPTH - 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          w_ena,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic                          w_ready,
    input  logic                          r_ena,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          r_valid,
    output logic                          avail,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          afull,
    output logic                          ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      w_ptr;
    logic [PTR_W-1:0]      r_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wacc;
    logic                  racc;

    // Full blocks writes even when a read is accepted in the same cycle, and
    // an empty queue ignores reads even when a write lands in the same cycle.
    assign wacc = w_ena && !full && !flush;
    assign racc = r_ena && (count != '0) && !flush;

    assign full  = (count == CNT_W'(DEPTH));
    assign afull = (count >= CNT_W'(AFULL_LVL));

    // Lookahead: with one entry left, a read this cycle empties the queue
    // (a same-cycle write is not yet readable); when empty, a write this
    // cycle makes data readable next cycle.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        avail = 1'b1;
        if (count == '0) begin
            avail = w_ena;
        end else if (count == CNT_W'(1)) begin
            avail = ~r_ena;
        end
    end

    arashi_thread_queue_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk    (clk),
        .rstn   (rstn),
        .w_en   (wacc),
        .w_addr (w_ptr),
        .w_data (data_in),
        .r_addr (r_ptr),
        .r_data (rd_data)
    );

    // DEPTH is a power of two, so pointer increments wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            count    <= '0;
            w_ready  <= 1'b0;
            r_valid  <= 1'b0;
            ovf_err  <= 1'b0;
            data_out <= '0;
        end else if (flush) begin
            // data_out and ovf_err deliberately hold across a flush.
            w_ptr   <= '0;
            r_ptr   <= '0;
            count   <= '0;
            w_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            w_ready <= wacc;
            r_valid <= racc;
            if (w_ena && full) begin
                ovf_err <= 1'b1;
            end
            if (wacc) begin
                w_ptr <= w_ptr + PTR_W'(1);
            end
            if (racc) begin
                r_ptr    <= r_ptr + PTR_W'(1);
                data_out <= rd_data;
            end
            if (wacc && !racc) begin
                count <= count + CNT_W'(1);
            end else if (racc && !wacc) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_arashi_thread_queue.sv
// ---------------------------------------------------------------------------
// tb_arashi_thread_queue
//   Self-checking bench: a queue-based reference model is compared against
//   the DUT on every falling edge; directed phases add literal expectations,
//   followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_arashi_thread_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AFL   = DEPTH - 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush = 1'b0;
    logic          w_ena = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          r_ena = 1'b0;
    logic          w_ready;
    logic [DW-1:0] data_out;
    logic          r_valid;
    logic          avail;
    logic [3:0]    count;
    logic          full;
    logic          afull;
    logic          ovf_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    arashi_thread_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AFULL_LVL  (AFL)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .w_ena    (w_ena),
        .data_in  (data_in),
        .w_ready  (w_ready),
        .r_ena    (r_ena),
        .data_out (data_out),
        .r_valid  (r_valid),
        .avail    (avail),
        .count    (count),
        .full     (full),
        .afull    (afull),
        .ovf_err  (ovf_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_wr = 1'b0;
    logic          m_rv = 1'b0;
    logic          m_ovf = 1'b0;
    bit            started = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            mq.delete();
            m_dout = '0;
            m_wr = 1'b0;
            m_rv = 1'b0;
            m_ovf = 1'b0;
            started = 1'b1;
        end else if (flush) begin
            mq.delete();
            m_wr = 1'b0;
            m_rv = 1'b0;
        end else begin
            bit was_full, wa, ra;
            was_full = (mq.size() == DEPTH);
            wa = w_ena && !was_full;
            ra = r_ena && (mq.size() != 0);
            if (w_ena && was_full) m_ovf = 1'b1;
            if (ra) m_dout = mq.pop_front();
            if (wa) mq.push_back(data_in);
            m_wr = wa;
            m_rv = ra;
        end
    end

    function automatic bit model_avail();
        if (mq.size() == 0) return w_ena;
        if (mq.size() == 1) return !r_ena;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("count",    32'(count),   32'(mq.size()));
            check("full",     32'(full),    32'(mq.size() == DEPTH));
            check("afull",    32'(afull),   32'(mq.size() >= AFL));
            check("w_ready",  32'(w_ready), 32'(m_wr));
            check("r_valid",  32'(r_valid), 32'(m_rv));
            check("data_out", data_out,     m_dout);
            check("ovf_err",  32'(ovf_err), 32'(m_ovf));
            check("avail",    32'(avail),   32'(model_avail()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        w_ena = w; data_in = d; r_ena = r; flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] held;

        rstn = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rstn = 1'b1;
        check("rst_count", 32'(count), 0);
        check("rst_full",  32'(full),  0);
        check("rst_afull", 32'(afull), 0);
        w_ena = 1'b1; #1;
        check("rst_avail_w1", 32'(avail), 1);
        w_ena = 1'b0; #1;
        check("rst_avail_w0", 32'(avail), 0);

        // fill
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, DW'(i + 1), 0, 0);
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_wready", 32'(w_ready), 1);
            check("fill_afull", 32'(afull), 32'((i + 1) >= 6));
        end
        check("fill_full", 32'(full), 1);
        cyc(1, 32'h99, 0, 0);
        check("ovf_wready", 32'(w_ready), 0);
        check("ovf_err",    32'(ovf_err), 1);
        check("ovf_count",  32'(count),   8);

        // drain
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 1, 0);
            check("drain_rvalid", 32'(r_valid), 1);
            check("drain_data",   data_out,     32'(i + 1));
        end
        check("drain_count", 32'(count), 0);
        cyc(0, 0, 1, 0);
        check("empty_rvalid", 32'(r_valid), 0);
        check("empty_hold",   data_out,     32'h8);

        // simultaneous read/write at count 3, pointers wrap
        for (int i = 0; i < 3; i++) cyc(1, 32'h100 + DW'(i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 32'h103 + DW'(i), 1, 0);
            check("simul_count", 32'(count), 3);
            check("simul_data",  data_out,   32'h100 + 32'(i));
        end

        // avail at count 1 / 2
        while (count != 0) cyc(0, 0, 1, 0);
        cyc(1, 32'h55, 0, 0);
        r_ena = 1'b1; #1;
        check("avail_c1_r1", 32'(avail), 0);
        r_ena = 1'b0;
        cyc(1, 32'h56, 0, 0);
        r_ena = 1'b1; #1;
        check("avail_c2_r1", 32'(avail), 1);
        r_ena = 1'b0;

        // flush at count 5
        for (int i = 0; i < 3; i++) cyc(1, 32'h60 + DW'(i), 0, 0);
        check("pre_flush_count", 32'(count), 5);
        held = m_dout;
        cyc(1, 32'h77, 1, 1);
        check("flush_count",  32'(count),   0);
        check("flush_wready", 32'(w_ready), 0);
        check("flush_rvalid", 32'(r_valid), 0);
        check("flush_dout",   data_out,     held);
        check("flush_ovf",    32'(ovf_err), 1);

        // reset mid-stream at count 4
        for (int i = 0; i < 4; i++) cyc(1, 32'h200 + DW'(i), 0, 0);
        rstn = 1'b0;
        cyc(1, 32'h300, 1, 0);
        rstn = 1'b1;
        check("mrst_count", 32'(count),    0);
        check("mrst_dout",  data_out,      0);
        check("mrst_ovf",   32'(ovf_err),  0);
        check("mrst_rv",    32'(r_valid),  0);
        check("mrst_wr",    32'(w_ready),  0);
        cyc(1, 32'hABC, 0, 0);
        cyc(0, 0, 1, 0);
        check("mrst_new", data_out, 32'hABC);
        check("mrst_new_rv", 32'(r_valid), 1);

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 199) != 0);
            cyc($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
                $urandom_range(0, 99) < 2);
        end
        rstn = 1'b1;
        cyc(0, 0, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arashi_thread_queue.md
ARASHI_THREAD_QUEUE -- requirements
Module: arashi_thread_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 2.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2, occupancy at which afull asserts; range 1..DEPTH.
REQ-004 SHALL derive localparams PTR_W = $clog2(DEPTH) and CNT_W = PTR_W+1.
REQ-005 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-006 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port flush  input  1  synchronous queue clear.
REQ-008 SHALL have port w_ena  input  1  write request.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  write payload.
REQ-010 SHALL have port w_ready  output  1  registered write-accepted pulse.
REQ-011 SHALL have port r_ena  input  1  read request.
REQ-012 SHALL have port data_out  output  DATA_WIDTH  registered read payload.
REQ-013 SHALL have port r_valid  output  1  registered: data_out updated last edge.
REQ-014 SHALL have port avail  output  1  combinational lookahead: data readable next cycle.
REQ-015 SHALL have port count  output  CNT_W  registered occupancy, 0..DEPTH.
REQ-016 SHALL have ports full, afull  output  1 each  count==DEPTH, count>=AFULL_LVL.
REQ-017 SHALL have port ovf_err  output  1  sticky dropped-write flag.

Function
REQ-018 SHALL accept a write (wacc) when w_ena && !full && !flush; entry stored at w_ptr, w_ptr increments mod DEPTH.
REQ-019 SHALL accept a read (racc) when r_ena && count!=0 && !flush; data_out <= entry at r_ptr, r_ptr increments mod DEPTH.
REQ-020 SHALL use all DEPTH entries (no sacrificed slot); occupancy tracked by count, not pointer difference.
REQ-021 SHALL update count <= count + wacc - racc; simultaneous wacc and racc leaves count unchanged.
REQ-022 SHALL NOT accept a write when full even if racc occurs in the same cycle.
REQ-023 SHALL NOT return same-cycle written data on a read when count==0 (no bypass); read is ignored.
REQ-024 SHALL set w_ready <= wacc and r_valid <= racc each cycle (one-cycle latency, one-cycle pulse per transfer).
REQ-025 SHALL hold data_out when no racc.
REQ-026 SHALL drive avail = w_ena when count==0; ~r_ena when count==1; 1 when count>=2.
REQ-027 SHALL set ovf_err when w_ena && full && !flush; clear only by reset.
REQ-028 SHALL on flush clear w_ptr, r_ptr, count, w_ready, r_valid next edge, discarding same-cycle w_ena/r_ena; data_out and ovf_err hold.
REQ-029 SHALL derive full and afull combinationally from registered count.

Reset
REQ-030 SHALL on !rstn clear w_ptr, r_ptr, count, w_ready, r_valid, ovf_err, data_out and all storage entries to 0.
REQ-031 SHALL give reset priority over flush, w_ena, r_ena; mid-operation reset discards all queued data.
REQ-032 SHALL after reset show count=0, full=0, afull=0 (AFULL_LVL>=1), avail=w_ena.

Structure
REQ-033 SHALL require no shared package; PTR_W/CNT_W stay local localparams.
REQ-034 SHALL place storage in sub-module arashi_thread_queue_mem (1W1R register array, DEPTH x DATA_WIDTH, sync write, async read, reset-clearable).
REQ-035 SHALL keep pointers, count, handshake and flags in the top module.

Verification
REQ-036 SHALL cover fill: DEPTH=8, 8 writes 0x1..0x8, no reads -> count=8, full=1, afull=1 from count 6, 9th write: w_ready=0, ovf_err=1.
REQ-037 SHALL cover drain order: after fill, 8 reads -> r_valid pulses, data_out 0x1..0x8 in order, count=0, 9th read: r_valid=0, data_out holds 0x8.
REQ-038 SHALL cover simultaneous: count=3, w_ena+r_ena for 20 cycles -> count stays 3, pointers wrap, output order preserved.
REQ-039 SHALL cover avail: count=0,w_ena=1 -> avail=1; count=1,r_ena=1 -> avail=0; count=2 -> avail=1.
REQ-040 SHALL cover flush: count=5, flush with w_ena+r_ena -> next cycle count=0, w_ready=0, r_valid=0, data_out unchanged, ovf_err unchanged.
REQ-041 SHALL cover reset mid-stream: count=4, rstn=0 one cycle -> all outputs 0, ovf_err cleared, subsequent write/read returns new data only.
